// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module : traffic_pkg
// Brief  : Shared request ids, scheduler state encoding and the round-robin
//          helpers used by traffic_request_scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    localparam int NUM_REQ = 3;

    // Request / grant identifiers (index into pending[])
    localparam logic [1:0] REQ_LEFT    = 2'd0;
    localparam logic [1:0] REQ_WALK_NS = 2'd1;
    localparam logic [1:0] REQ_WALK_EW = 2'd2;

    // Scheduler state encoding
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] OFFER   = 2'd1;
    localparam logic [1:0] SERVING = 2'd2;

    // Next id in the 0 -> 1 -> 2 -> 0 ring
    function automatic logic [1:0] rr_inc(input logic [1:0] id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

    // First pending id found searching ptr, ptr+1, ptr+2 (mod 3)
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        idx   = ptr;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
            idx = rr_inc(idx);
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_request_scheduler_key_debouncer.sv
`default_nettype none
// ============================================================================
// Module : key_debouncer
// Brief  : 2-FF synchroniser, stable-level debouncer and press pulse for one
//          active-low pushbutton. i_bypass passes the synchronised level.
// Rev    : 1.0  initial release
// ============================================================================
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_bypass,
    input  logic i_key_n,
    output logic o_press
);

    localparam int             CW          = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  C_CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          w_deb_nxt;
    logic [CW-1:0] r_cnt;

    // Two-stage synchroniser; released (high) level out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Debounced level follows sync once it has differed for DEBOUNCE_CYCLES cycles
    always_comb begin
        w_deb_nxt = r_deb;
        if (i_bypass) begin
            w_deb_nxt = r_sync2;
        end else if ((r_sync2 != r_deb) && (r_cnt == C_CNT_LAST)) begin
            w_deb_nxt = r_sync2;
        end
    end

    // Stability counter and debounced level register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_deb <= 1'b1;
        end else begin
            r_deb <= w_deb_nxt;
            if (i_bypass || (r_sync2 == r_deb) || (r_cnt == C_CNT_LAST)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Press fires in the cycle the debounced level is about to fall, so the
    // pending bit lands on the same edge the debounced level goes low
    assign o_press = r_deb & ~w_deb_nxt;

endmodule
`default_nettype wire

// File: rtl/traffic_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module : traffic_request_scheduler
// Brief  : Debounces three request keys, latches them as pending requests and
//          offers them round-robin to the phase sequencer over valid/ack,
//          tracking each service until phase_done or a timeout.
// Rev    : 1.0  initial release
// ============================================================================
module traffic_request_scheduler
    import traffic_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 270000,
    parameter int unsigned SERVE_TIMEOUT   = 1620000000
) (
    input  logic       clk_27,
    input  logic       reset,
    input  logic       sw9,
    input  logic       key_1,
    input  logic       key_3,
    input  logic       key_2,
    input  logic       safe_point,
    input  logic       grant_ack,
    input  logic       phase_done,
    output logic       grant_valid,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic [2:0] pending,
    output logic       timeout_err
);

    localparam logic [31:0] C_SERVE_LAST = 32'(SERVE_TIMEOUT - 1);

    logic [2:0]  w_keys_n;
    logic [2:0]  w_press;
    logic [2:0]  w_clr;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  r_rr_ptr;
    logic [1:0]  w_rr_nxt;
    logic [1:0]  r_grant_id;
    logic [1:0]  w_grant_id_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic [2:0]  r_pending;
    logic        r_timeout;
    logic        w_timeout_nxt;

    // Bit order matches pending[]: {WALK_EW, WALK_NS, LEFT}
    assign w_keys_n = {key_2, key_3, key_1};

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_key_debouncer (
                .clk      (clk_27),
                .rst_n    (reset),
                .i_bypass (sw9),
                .i_key_n  (w_keys_n[g]),
                .o_press  (w_press[g])
            );
        end
    endgenerate

    // Next-state, arbitration and service-timer logic
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr_ptr;
        w_grant_id_nxt = r_grant_id;
        w_cnt_nxt      = r_cnt;
        w_timeout_nxt  = r_timeout;
        w_clr          = '0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if ((r_pending != 3'b000) && safe_point) begin
                    w_grant_id_nxt = rr_pick(r_pending, r_rr_ptr);
                    w_state_nxt    = OFFER;
                end
            end
            OFFER: begin
                // Offer stays up regardless of safe_point until acknowledged
                if (grant_ack) begin
                    w_clr[r_grant_id] = 1'b1;
                    w_rr_nxt          = rr_inc(r_grant_id);
                    w_cnt_nxt         = '0;
                    w_state_nxt       = SERVING;
                end
            end
            SERVING: begin
                if (phase_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (r_cnt == C_SERVE_LAST) begin
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, arbitration pointer, grant id, timer, pending and sticky error
    always_ff @(posedge clk_27 or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= 2'd0;
            r_grant_id <= REQ_LEFT;
            r_cnt      <= '0;
            r_pending  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_cnt      <= w_cnt_nxt;
            // A press landing on the clearing handshake keeps the request
            r_pending  <= (r_pending & ~w_clr) | w_press;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign grant_valid = (r_state == OFFER);
    assign busy        = (r_state == SERVING);
    assign grant_id    = r_grant_id;
    assign pending     = r_pending;
    assign timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_traffic_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_traffic_request_scheduler
// Brief  : Self-checking bench; expected grant ids are queued when keys are
//          pressed and compared as the scheduler offers grants.
// Rev    : 1.0  initial release
// ============================================================================
module tb_traffic_request_scheduler;

    logic       clk_27 = 1'b0;
    logic       reset;
    logic       sw9;
    logic       key_1;
    logic       key_3;
    logic       key_2;
    logic       safe_point;
    logic       grant_ack;
    logic       phase_done;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       busy;
    logic [2:0] pending;
    logic       timeout_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] sb[$];

    traffic_request_scheduler #(
        .DEBOUNCE_CYCLES (4),
        .SERVE_TIMEOUT   (20)
    ) dut (
        .clk_27      (clk_27),
        .reset       (reset),
        .sw9         (sw9),
        .key_1       (key_1),
        .key_3       (key_3),
        .key_2       (key_2),
        .safe_point  (safe_point),
        .grant_ack   (grant_ack),
        .phase_done  (phase_done),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .busy        (busy),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    always #5 clk_27 = ~clk_27;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_27);
    endtask

    // Drive the given keys low for two cycles ({key_2, key_3, key_1})
    task automatic press(input logic [2:0] mask);
        key_1 = ~mask[0];
        key_3 = ~mask[1];
        key_2 = ~mask[2];
        tick(2);
        key_1 = 1'b1;
        key_3 = 1'b1;
        key_2 = 1'b1;
    endtask

    task automatic take_grant(input string tag);
        logic [1:0] exp_id;
        int         i;
        i = 0;
        while (!grant_valid && i < 100) begin
            tick(1);
            i++;
        end
        check({tag, "_offer_seen"}, grant_valid, 1'b1);
        check({tag, "_sb_empty"}, (sb.size() == 0), 1'b0);
        if (grant_valid && sb.size() != 0) begin
            exp_id = sb.pop_front();
            check({tag, "_id"}, grant_id, exp_id);
        end
    endtask

    task automatic ack_grant(input string tag);
        grant_ack = 1'b1;
        tick(1);
        grant_ack = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_valid_drop"}, grant_valid, 1'b0);
    endtask

    task automatic finish_phase(input string tag);
        phase_done = 1'b1;
        tick(1);
        phase_done = 1'b0;
        check({tag, "_done_busy"}, busy, 1'b0);
    endtask

    task automatic serve(input string tag);
        take_grant(tag);
        ack_grant(tag);
        finish_phase(tag);
    endtask

    // Main stimulus sequence
    initial begin
        reset      = 1'b0;
        sw9        = 1'b0;
        key_1      = 1'b1;
        key_3      = 1'b1;
        key_2      = 1'b1;
        safe_point = 1'b0;
        grant_ack  = 1'b0;
        phase_done = 1'b0;
        tick(3);
        check("rst_valid",   grant_valid, 1'b0);
        check("rst_id",      grant_id,    2'd0);
        check("rst_busy",    busy,        1'b0);
        check("rst_pending", pending,     3'b000);
        check("rst_timeout", timeout_err, 1'b0);
        reset = 1'b1;
        tick(3);

        // 1: short bounce is rejected, long hold is accepted
        key_3 = 1'b0;
        tick(2);
        key_3 = 1'b1;
        tick(10);
        check("bounce_rejected", pending, 3'b000);
        key_3 = 1'b0;
        tick(8);
        key_3 = 1'b1;
        tick(2);
        check("debounced_walk_ns", pending, 3'b010);
        check("no_offer_unsafe", grant_valid, 1'b0);
        tick(10);
        sb.push_back(2'd1);
        safe_point = 1'b1;
        serve("t1_clear");

        // 2: bypass latency and single grant
        sw9 = 1'b1;
        tick(2);
        key_1 = 1'b0;
        sb.push_back(2'd0);
        tick(2);
        check("lat_early", pending, 3'b000);
        tick(1);
        check("lat_3cyc", pending, 3'b001);
        key_1 = 1'b1;
        take_grant("t2");
        ack_grant("t2");
        check("t2_pending_clr", pending, 3'b000);
        finish_phase("t2");
        tick(2);
        check("t2_idle", grant_valid | busy, 1'b0);

        // 3: simultaneous presses, rr_ptr=1 first then rr_ptr=0
        press(3'b111);
        sb.push_back(2'd1);
        sb.push_back(2'd2);
        sb.push_back(2'd0);
        serve("t3a_g0");
        serve("t3a_g1");
        serve("t3a_g2");
        press(3'b100);
        sb.push_back(2'd2);
        serve("t3_move_ptr");
        press(3'b111);
        sb.push_back(2'd0);
        sb.push_back(2'd1);
        sb.push_back(2'd2);
        serve("t3b_g0");
        serve("t3b_g1");
        serve("t3b_g2");

        // 4: offer held while safe_point low and no ack
        press(3'b010);
        tick(4);
        check("t4_offer_valid", grant_valid, 1'b1);
        check("t4_offer_id", grant_id, 2'd1);
        safe_point = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t4_hold_valid", grant_valid, 1'b1);
            check("t4_hold_id", grant_id, 2'd1);
        end
        sb.push_back(2'd1);
        serve("t4");
        safe_point = 1'b1;

        // 5: service timeout without phase_done
        press(3'b100);
        sb.push_back(2'd2);
        take_grant("t5");
        ack_grant("t5");
        tick(19);
        check("t5_busy_before_to", busy, 1'b1);
        check("t5_err_before_to", timeout_err, 1'b0);
        tick(1);
        check("t5_busy_after_to", busy, 1'b0);
        check("t5_err_after_to", timeout_err, 1'b1);

        // 6: press landing on the handshake cycle keeps the request
        press(3'b100);
        sb.push_back(2'd2);
        take_grant("t6");
        tick(2);
        key_2 = 1'b0;
        tick(2);
        grant_ack = 1'b1;
        tick(1);
        grant_ack = 1'b0;
        key_2     = 1'b1;
        check("t6_pending_kept", pending[2], 1'b1);
        check("t6_busy", busy, 1'b1);
        check("t6_err_sticky", timeout_err, 1'b1);
        finish_phase("t6");
        sb.push_back(2'd2);
        take_grant("t6_again");
        ack_grant("t6_again");
        check("t6_err_still", timeout_err, 1'b1);

        // Asynchronous reset in the middle of SERVING
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid",   grant_valid, 1'b0);
        check("arst_id",      grant_id,    2'd0);
        check("arst_busy",    busy,        1'b0);
        check("arst_pending", pending,     3'b000);
        check("arst_timeout", timeout_err, 1'b0);
        tick(2);
        reset = 1'b1;
        tick(2);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
